// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the multi-bit shift sequencer and the ALU shift unit.
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam logic [1:0] SHIFT_A_RIGHT = 2'b00;
  localparam logic [1:0] SHIFT_A_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_B_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_B_LEFT  = 2'b11;

endpackage

// File: rtl/shift_seq_ctrl.sv
// Drives a one-bit, one-cycle-latency shift unit repeatedly to perform a
// multi-bit logical shift; all outputs are registered.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic             Cmd_Dir,
  input  logic [WIDTH-1:0] Cmd_Data,
  input  logic [CNT_W-1:0] Cmd_Count,
  output logic             Shift_Enable,
  output logic [1:0]       Shift_Fun,
  output logic [WIDTH-1:0] Shift_A,
  output logic [WIDTH-1:0] Shift_B,
  input  logic [WIDTH-1:0] Shift_Out,
  input  logic             Shift_Flag,
  output logic [WIDTH-1:0] Res_Data,
  output logic             Res_Valid,
  output logic             Busy
);

  seq_state_t       state_q;
  logic [WIDTH-1:0] work_q;
  logic [CNT_W-1:0] remaining_q;
  logic             dir_q;
  logic             ready_q;
  logic             busy_q;
  logic             shift_en_q;
  logic [1:0]       shift_fun_q;
  logic [WIDTH-1:0] shift_a_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_valid_q;

  // Outputs are set on the edge that enters a state, so they line up with it.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      shift_fun_q <= SHIFT_A_RIGHT;
      shift_a_q   <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      // Operand bus and enable are idle-low except while issuing.
      shift_en_q  <= 1'b0;
      shift_fun_q <= SHIFT_A_RIGHT;
      shift_a_q   <= '0;
      res_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Cmd_Valid) begin
            work_q      <= Cmd_Data;
            remaining_q <= Cmd_Count;
            dir_q       <= Cmd_Dir;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            if (Cmd_Count == '0) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= Cmd_Data;
            end else begin
              state_q     <= ISSUE;
              shift_en_q  <= 1'b1;
              shift_fun_q <= {1'b0, Cmd_Dir};
              shift_a_q   <= Cmd_Data;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (Shift_Flag) begin
            work_q      <= Shift_Out;
            remaining_q <= remaining_q - 1'b1;
            // A zero operand cannot change further, so stop early.
            if (remaining_q == CNT_W'(1) || Shift_Out == '0) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= Shift_Out;
            end else begin
              state_q     <= ISSUE;
              shift_en_q  <= 1'b1;
              shift_fun_q <= {1'b0, dir_q};
              shift_a_q   <= Shift_Out;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Cmd_Ready    = ready_q;
  assign Busy         = busy_q;
  assign Shift_Enable = shift_en_q;
  assign Shift_Fun    = shift_fun_q;
  assign Shift_A      = shift_a_q;
  assign Shift_B      = '0;
  assign Res_Data     = res_data_q;
  assign Res_Valid    = res_valid_q;

endmodule
